block_pipe_out_arbiter: RTL and testbench

BLOCK_PIPE_OUT_ARBITER -- requirements
Module: block_pipe_out_arbiter

---
 rtl/block_pipe_out_arbiter.sv | 144 ++++++++++++++
 tb/tb_block_pipe_out_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_pipe_out_arbiter.sv
// Two-requester round-robin arbiter that feeds whole blocks into an okBTPipeOut endpoint.
// A requester is served only once it holds a full block, and the grant stays fixed until that block is drained.
module block_pipe_out_arbiter #(
    parameter int unsigned BLOCK_WORDS = 4,
    parameter int unsigned LEVEL_W     = 8
) (
    input  logic               okClk,
    input  logic               rst,
    input  logic               ep_read,
    input  logic               ep_blockstrobe,
    output logic               ep_ready,
    output logic [31:0]        ep_datain,
    input  logic [31:0]        req0_data,
    input  logic [31:0]        req1_data,
    input  logic [LEVEL_W-1:0] req0_level,
    input  logic [LEVEL_W-1:0] req1_level,
    output logic               req0_pop,
    output logic               req1_pop,
    output logic               grant,
    output logic [15:0]        blocks0,
    output logic [15:0]        blocks1,
    output logic               underrun
);

    localparam int unsigned CntW = $clog2(BLOCK_WORDS);
    // Wide enough to hold both any level value and BLOCK_WORDS itself.
    localparam int unsigned CmpW = (LEVEL_W > CntW + 1) ? LEVEL_W : CntW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } state_e;

    state_e            state_q;
    logic              ep_ready_q;
    logic [31:0]       ep_datain_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [CntW-1:0]   word_cnt_q;
    logic [15:0]       blocks0_q;
    logic [15:0]       blocks1_q;
    logic              underrun_q;

    logic [CmpW-1:0]   lvl0_ext;
    logic [CmpW-1:0]   lvl1_ext;
    logic [CmpW-1:0]   block_thresh;
    logic              elig0;
    logic              elig1;
    logic              pick_valid;
    logic              pick_idx;
    logic              last_word;
    logic              xfer_rd;
    logic [31:0]       sel_data;
    logic              unused_blockstrobe;

    // Block-start strobe is informational only.
    assign unused_blockstrobe = ep_blockstrobe;

    assign lvl0_ext     = CmpW'(req0_level);
    assign lvl1_ext     = CmpW'(req1_level);
    assign block_thresh = CmpW'(BLOCK_WORDS);
    assign elig0        = (lvl0_ext >= block_thresh);
    assign elig1        = (lvl1_ext >= block_thresh);

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 1'b0;
        if (elig0 && elig1) begin
            pick_valid = 1'b1;
            pick_idx   = ~last_grant_q;
        end else if (elig0) begin
            pick_valid = 1'b1;
            pick_idx   = 1'b0;
        end else if (elig1) begin
            pick_valid = 1'b1;
            pick_idx   = 1'b1;
        end
    end

    assign last_word = (word_cnt_q == CntW'(BLOCK_WORDS - 1));
    assign sel_data  = grant_q ? req1_data : req0_data;

    // Reset masks pops so an aborted block never consumes a FIFO word.
    assign xfer_rd  = (state_q == StXfer) && ep_read && !rst;
    assign req0_pop = xfer_rd && !grant_q;
    assign req1_pop = xfer_rd && grant_q;

    always_ff @(posedge okClk) begin
        if (rst) begin
            state_q      <= StIdle;
            ep_ready_q   <= 1'b0;
            ep_datain_q  <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            word_cnt_q   <= '0;
            blocks0_q    <= '0;
            blocks1_q    <= '0;
            underrun_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ep_read) begin
                        underrun_q  <= 1'b1;
                        ep_datain_q <= '0;
                    end
                    if (pick_valid) begin
                        grant_q      <= pick_idx;
                        last_grant_q <= pick_idx;
                        word_cnt_q   <= '0;
                        state_q      <= StXfer;
                        ep_ready_q   <= 1'b1;
                    end
                end
                StXfer: begin
                    if (ep_read) begin
                        ep_datain_q <= sel_data;
                        word_cnt_q  <= word_cnt_q + 1'b1;
                        if (last_word) begin
                            state_q    <= StIdle;
                            ep_ready_q <= 1'b0;
                            if (grant_q) begin
                                blocks1_q <= blocks1_q + 16'd1;
                            end else begin
                                blocks0_q <= blocks0_q + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    ep_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ep_ready  = ep_ready_q;
    assign ep_datain = ep_datain_q;
    assign grant     = grant_q;
    assign blocks0   = blocks0_q;
    assign blocks1   = blocks1_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_block_pipe_out_arbiter.sv
// Directed bench for block_pipe_out_arbiter: single block, round-robin ties, grant lock,
// underrun, mid-block reset, block-counter wrap and the eligibility threshold.
module tb_block_pipe_out_arbiter;

    localparam int unsigned BW = 4;

    logic        okClk;
    logic        rst;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic        ep_ready;
    logic [31:0] ep_datain;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic [7:0]  req0_level;
    logic [7:0]  req1_level;
    logic        req0_pop;
    logic        req1_pop;
    logic        grant;
    logic [15:0] blocks0;
    logic [15:0] blocks1;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    block_pipe_out_arbiter #(
        .BLOCK_WORDS (BW),
        .LEVEL_W     (8)
    ) dut (
        .okClk          (okClk),
        .rst            (rst),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_ready       (ep_ready),
        .ep_datain      (ep_datain),
        .req0_data      (req0_data),
        .req1_data      (req1_data),
        .req0_level     (req0_level),
        .req1_level     (req1_level),
        .req0_pop       (req0_pop),
        .req1_pop       (req1_pop),
        .grant          (grant),
        .blocks0        (blocks0),
        .blocks1        (blocks1),
        .underrun       (underrun)
    );

    initial begin
        okClk = 1'b0;
        forever #5 okClk = ~okClk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge okClk);
        #1;
    endtask

    // Issues count back-to-back reads on requester who, words first..first+count-1.
    task automatic read_words(input int who, input logic [31:0] base, input int first,
                              input int count);
        for (int i = first; i < first + count; i++) begin
            ep_read = 1'b1;
            if (who == 0) begin
                req0_data = base + i;
                req1_data = 32'hBAD0_0000 + i;
            end else begin
                req1_data = base + i;
                req0_data = 32'hBAD0_0000 + i;
            end
            #1;
            chk("pop0", {31'b0, req0_pop}, (who == 0) ? 32'd1 : 32'd0);
            chk("pop1", {31'b0, req1_pop}, (who == 1) ? 32'd1 : 32'd0);
            tick();
            ep_read = 1'b0;
            chk("datain", ep_datain, base + i);
            chk("grant_lock", {31'b0, grant}, who);
            chk("ready_in_block", {31'b0, ep_ready}, (i == BW - 1) ? 32'd0 : 32'd1);
        end
    endtask

    initial begin
        rst            = 1'b1;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        req0_data      = '0;
        req1_data      = '0;
        req0_level     = '0;
        req1_level     = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, ep_ready}, 0);
        chk("rst_datain", ep_datain, 0);
        chk("rst_grant", {31'b0, grant}, 0);
        chk("rst_blocks0", {16'b0, blocks0}, 0);
        chk("rst_blocks1", {16'b0, blocks1}, 0);
        chk("rst_underrun", {31'b0, underrun}, 0);
        chk("rst_pops", {30'b0, req1_pop, req0_pop}, 0);

        // Single block on req0.
        rst = 1'b0;
        tick();
        chk("idle_no_level", {31'b0, ep_ready}, 0);
        req0_level     = 8'd4;
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
        chk("single_ready", {31'b0, ep_ready}, 1);
        chk("single_grant", {31'b0, grant}, 0);
        read_words(0, 32'hA0, 0, BW);
        req0_level = '0;
        chk("single_blocks0", {16'b0, blocks0}, 1);

        // Tie after reset: req0, req1, req0.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req0_level = 8'd8;
        req1_level = 8'd8;
        tick();
        chk("tie1_grant", {31'b0, grant}, 0);
        chk("tie1_ready", {31'b0, ep_ready}, 1);
        read_words(0, 32'h100, 0, BW);
        tick();
        chk("tie2_grant", {31'b0, grant}, 1);
        chk("tie2_ready", {31'b0, ep_ready}, 1);
        read_words(1, 32'h200, 0, BW);
        tick();
        chk("tie3_grant", {31'b0, grant}, 0);
        read_words(0, 32'h300, 0, BW);
        req0_level = '0;
        req1_level = '0;
        chk("tie_blocks0", {16'b0, blocks0}, 2);
        chk("tie_blocks1", {16'b0, blocks1}, 1);

        // Grant lock: req1 becomes eligible mid-block.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        req0_level = 8'd4;
        tick();
        chk("lock_grant", {31'b0, grant}, 0);
        read_words(0, 32'h400, 0, 2);
        req1_level = 8'd8;
        read_words(0, 32'h400, 2, 2);
        req0_level = '0;
        tick();
        chk("lock_next_grant", {31'b0, grant}, 1);
        chk("lock_next_ready", {31'b0, ep_ready}, 1);
        read_words(1, 32'h500, 0, BW);
        req1_level = '0;

        // Underrun: read in IDLE while ep_datain holds 0x503.
        ep_read = 1'b1;
        #1;
        chk("ur_pops", {30'b0, req1_pop, req0_pop}, 0);
        tick();
        ep_read = 1'b0;
        chk("ur_flag", {31'b0, underrun}, 1);
        chk("ur_datain", ep_datain, 0);
        chk("ur_ready", {31'b0, ep_ready}, 0);
        req0_level = 8'd4;
        tick();
        read_words(0, 32'h600, 0, BW);
        req0_level = '0;
        chk("ur_sticky", {31'b0, underrun}, 1);
        chk("ur_blocks0", {16'b0, blocks0}, 2);

        // Mid-block reset after two reads.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ur_cleared", {31'b0, underrun}, 0);
        req0_level = 8'd4;
        tick();
        chk("mrst_ready", {31'b0, ep_ready}, 1);
        read_words(0, 32'h700, 0, 2);
        rst       = 1'b1;
        ep_read   = 1'b1;
        req0_data = 32'h777;
        #1;
        chk("mrst_pop0", {31'b0, req0_pop}, 0);
        tick();
        rst     = 1'b0;
        ep_read = 1'b0;
        chk("mrst_ready_low", {31'b0, ep_ready}, 0);
        chk("mrst_blocks0", {16'b0, blocks0}, 0);
        chk("mrst_datain", ep_datain, 0);
        chk("mrst_underrun", {31'b0, underrun}, 0);
        tick();
        chk("mrst_rearm_ready", {31'b0, ep_ready}, 1);
        chk("mrst_rearm_grant", {31'b0, grant}, 0);
        read_words(0, 32'h800, 0, BW);
        req0_level = '0;
        chk("mrst_blocks0_after", {16'b0, blocks0}, 1);

        // blocks1 wrap from 0xFFFF.
        force dut.blocks1_q = 16'hFFFF;
        #1;
        release dut.blocks1_q;
        chk("wrap_preset", {16'b0, blocks1}, 32'hFFFF);
        req1_level = 8'd4;
        tick();
        chk("wrap_grant", {31'b0, grant}, 1);
        read_words(1, 32'h900, 0, BW);
        req1_level = 8'd3;
        chk("wrap_blocks1", {16'b0, blocks1}, 0);
        chk("wrap_blocks0", {16'b0, blocks0}, 1);

        // Level one short of a block never arms; block strobe has no effect.
        ep_blockstrobe = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("inelig_ready", {31'b0, ep_ready}, 0);
        end
        ep_blockstrobe = 1'b0;
        chk("final_underrun", {31'b0, underrun}, 0);
        chk("final_datain", ep_datain, 32'h903);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
